// File: rtl/arbiter_weighted_round_robin_hs.sv
// Weighted round-robin arbiter: per-client credits loaded from weights, a registered
// one-hot grant that is held until acknowledged, and round-robin rotation on ack.
module arbiter_weighted_round_robin_hs #(
  parameter int CLIENTS  = 4,
  parameter int WEIGHT_W = 4,
  parameter int ID_W     = $clog2(CLIENTS)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [CLIENTS-1:0]           i_req,
  input  logic [CLIENTS*WEIGHT_W-1:0]  i_weights,
  input  logic                         i_replenish,
  input  logic                         i_grant_ack,
  output logic [CLIENTS-1:0]           o_grant,
  output logic                         o_grant_valid,
  output logic [ID_W-1:0]              o_grant_id
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                state_r;
  logic [WEIGHT_W-1:0]   credit_r [CLIENTS];
  logic [ID_W-1:0]       last_r;
  logic [CLIENTS-1:0]    grant_r;
  logic [ID_W-1:0]       grant_id_r;
  logic                  grant_valid_r;

  logic                  ack_s;
  logic                  arb_s;
  logic                  reload_s;
  logic                  found_s;
  logic [WEIGHT_W-1:0]   work_credit_s [CLIENTS];
  logic [ID_W-1:0]       work_last_s;
  logic [ID_W-1:0]       winner_s;
  logic [CLIENTS-1:0]    live_s;
  logic [CLIENTS-1:0]    elig_raw_s;
  logic [CLIENTS-1:0]    elig_s;
  logic [ID_W:0]         idx_s;

  // Working credits/pointer: an ack consumes the acked client's credit before arbitrating
  always_comb begin
    ack_s       = (state_r == GRANT) && i_grant_ack;
    arb_s       = (state_r == IDLE) || ack_s;
    work_last_s = ack_s ? grant_id_r : last_r;
    live_s      = '0;
    elig_raw_s  = '0;
    for (int k = 0; k < CLIENTS; k++) begin
      if (ack_s && (grant_id_r == ID_W'(k)) && (credit_r[k] != '0)) begin
        work_credit_s[k] = credit_r[k] - WEIGHT_W'(1);
      end else begin
        work_credit_s[k] = credit_r[k];
      end
      live_s[k]     = i_req[k] && (i_weights[k*WEIGHT_W +: WEIGHT_W] != '0);
      elig_raw_s[k] = i_req[k] && (work_credit_s[k] != '0);
    end
    reload_s = i_replenish || ((elig_raw_s == '0) && (live_s != '0));
    if (reload_s) begin
      elig_s = live_s;
    end else begin
      elig_s = elig_raw_s;
    end
  end

  // Cyclic first-set search starting just after the last acknowledged client
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    idx_s    = '0;
    for (int i = 1; i <= CLIENTS; i++) begin
      idx_s = {1'b0, work_last_s} + (ID_W+1)'(i);
      if (idx_s >= (ID_W+1)'(CLIENTS)) begin
        idx_s = idx_s - (ID_W+1)'(CLIENTS);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && elig_s[idx_s[ID_W-1:0]]) begin
        found_s  = 1'b1;
        winner_s = idx_s[ID_W-1:0];
      end else begin
        found_s  = found_s;
      end
    end
  end

  // State, credits, pointer and registered grant outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r       <= IDLE;
      last_r        <= ID_W'(CLIENTS-1);
      grant_r       <= '0;
      grant_id_r    <= '0;
      grant_valid_r <= 1'b0;
      for (int k = 0; k < CLIENTS; k++) begin
        credit_r[k] <= i_weights[k*WEIGHT_W +: WEIGHT_W];
      end
    end else if (arb_s) begin
      last_r <= work_last_s;
      for (int k = 0; k < CLIENTS; k++) begin
        credit_r[k] <= reload_s ? i_weights[k*WEIGHT_W +: WEIGHT_W] : work_credit_s[k];
      end
      case (found_s)
        1'b1: begin
          state_r       <= GRANT;
          grant_r       <= {{(CLIENTS-1){1'b0}}, 1'b1} << winner_s;
          grant_id_r    <= winner_s;
          grant_valid_r <= 1'b1;
        end
        default: begin
          state_r       <= IDLE;
          grant_r       <= '0;
          grant_id_r    <= '0;
          grant_valid_r <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  assign o_grant       = grant_r;
  assign o_grant_valid = grant_valid_r;
  assign o_grant_id    = grant_id_r;

endmodule

// File: tb/tb_arbiter_weighted_round_robin_hs.sv
// Self-checking bench: directed scenarios plus randomized traffic compared against a
// behavioural credit/round-robin model.
module tb_arbiter_weighted_round_robin_hs;

  localparam int N   = 4;
  localparam int W   = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   weights;
  logic             replenish;
  logic             ack;
  logic [N-1:0]     grant;
  logic             valid;
  logic [IDW-1:0]   gid;

  int tests_run    = 0;
  int tests_failed = 0;

  int m_credit [N];
  int m_last;
  bit m_valid;
  int m_id;

  always #5 clk = ~clk;

  arbiter_weighted_round_robin_hs #(.CLIENTS(N), .WEIGHT_W(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_weights(weights),
    .i_replenish(replenish), .i_grant_ack(ack),
    .o_grant(grant), .o_grant_valid(valid), .o_grant_id(gid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int wt(input int k);
    return int'(weights[k*W +: W]);
  endfunction

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    weights = {W'(w3), W'(w2), W'(w1), W'(w0)};
  endtask

  // Reference: credits, last-acked pointer and the outstanding grant, updated per edge
  task automatic model_step();
    bit has_elig;
    bit any_live;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) m_credit[k] = wt(k);
      m_last  = N - 1;
      m_valid = 0;
      m_id    = 0;
      return;
    end
    if (m_valid && !ack) return;
    if (m_valid) begin
      if (m_credit[m_id] > 0) m_credit[m_id] = m_credit[m_id] - 1;
      m_last = m_id;
    end
    has_elig = 0;
    any_live = 0;
    for (int k = 0; k < N; k++) begin
      if (req[k] && m_credit[k] > 0) has_elig = 1;
      if (req[k] && wt(k) != 0) any_live = 1;
    end
    if (replenish || (!has_elig && any_live))
      for (int k = 0; k < N; k++) m_credit[k] = wt(k);
    m_valid = 0;
    m_id    = 0;
    for (int s = 1; s <= N; s++) begin
      int c;
      c = (m_last + s) % N;
      if (req[c] && m_credit[c] > 0) begin
        m_valid = 1;
        m_id    = c;
        break;
      end
    end
  endtask

  // One clock: advance the model with the current inputs, then compare after the edge
  task automatic tick();
    logic [N-1:0] exp_grant;
    model_step();
    @(posedge clk);
    #1;
    exp_grant = m_valid ? (N'(1) << m_id) : '0;
    check_eq("valid", 32'(valid), 32'(m_valid));
    check_eq("grant", 32'(grant), 32'(exp_grant));
    if (m_valid) check_eq("grant_id", 32'(gid), 32'(m_id));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  int seq2 [8] = '{0, 1, 0, 0, 1, 0, 0, 0};

  initial begin
    rst_n = 1'b0; req = '0; replenish = 1'b0; ack = 1'b0;
    set_w(1, 1, 1, 1);
    @(negedge clk);

    // Reset state and plain rotation with unit weights
    do_reset();
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_grant", 32'(grant), 32'd0);
    req = 4'b1111; ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("t1_valid", 32'(valid), 32'd1);
      check_eq("t1_id", 32'(gid), 32'(i % 4));
    end

    // 3:1 weighting with reload before the fifth grant
    req = '0; ack = 1'b0;
    set_w(3, 1, 0, 0);
    do_reset();
    req = 4'b0011; ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("t2_id", 32'(gid), 32'(seq2[i]));
    end

    // Sticky grant while ack is low and requests toggle
    req = 4'b0010; ack = 1'b0;
    set_w(1, 1, 1, 1);
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      req = 4'($urandom_range(0, 15));
      tick();
      check_eq("t3_hold", 32'(grant), 32'b0010);
    end
    req = 4'b0010; ack = 1'b1;
    tick();
    check_eq("t3_after_ack", 32'(grant), 32'b0010);

    // Zero-weight client never wins until weight is set and replenished
    ack = 1'b0; req = 4'b1000;
    set_w(1, 1, 1, 0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t4_idle", 32'(valid), 32'd0);
    end
    set_w(1, 1, 1, 2);
    replenish = 1'b1;
    tick();
    replenish = 1'b0;
    check_eq("t4_id", 32'(gid), 32'd3);
    check_eq("t4_valid", 32'(valid), 32'd1);

    // Reset while a grant is outstanding
    rst_n = 1'b0;
    tick();
    check_eq("t5_cleared", 32'(grant), 32'd0);
    set_w(1, 1, 1, 1); req = 4'b1111; ack = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("t5_first", 32'(gid), 32'd0);

    // Single client, weight 2: back-to-back grants across reloads
    req = '0;
    set_w(0, 0, 2, 0);
    do_reset();
    req = 4'b0100; ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("t6_grant", 32'(grant), 32'b0100);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      req       = 4'($urandom_range(0, 15));
      ack       = ($urandom_range(0, 3) != 0);
      replenish = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0)
        set_w($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
